// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage: one product/quotient bit per cycle,
// drives the pipeline stall while running and commits HI/LO on completion.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t r_state, w_next_state;

  logic [CW-1:0]      r_cnt;
  logic               r_is_div, r_neg_q, r_neg_r, r_dbz;
  logic [WIDTH-1:0]   r_b, r_wh, r_wl, r_hi, r_lo;

  logic               w_accept, w_dbz_req, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_sum, w_rs;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff, w_step_hi, w_step_lo, w_fix_hi, w_fix_lo;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  assign w_accept  = (r_state == S_IDLE) && start_i && !flush_i;
  assign w_dbz_req = op_i[1] && (src_b_i == '0);
  assign w_a_neg   = !op_i[0] && src_a_i[WIDTH-1];
  assign w_b_neg   = !op_i[0] && src_b_i[WIDTH-1];
  assign w_a_mag   = w_a_neg ? -src_a_i : src_a_i;
  assign w_b_mag   = w_b_neg ? -src_b_i : src_b_i;

  // Multiply step: conditional add of the multiplicand, then shift {carry,hi,lo} right
  assign w_sum = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_b} : '0);

  // Divide step: shift next dividend bit into the partial remainder, subtract if it fits
  assign w_rs   = {r_wh, r_wl[WIDTH-1]};
  assign w_ge   = (w_rs >= {1'b0, r_b});
  assign w_diff = w_rs[WIDTH-1:0] - r_b;

  assign w_step_hi = r_is_div ? (w_ge ? w_diff : w_rs[WIDTH-1:0]) : w_sum[WIDTH:1];
  assign w_step_lo = r_is_div ? {r_wl[WIDTH-2:0], w_ge} : {w_sum[0], r_wl[WIDTH-1:1]};

  // Sign fix applied to the final step's result on the commit edge
  assign w_prod     = {w_step_hi, w_step_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_fix_hi   = r_is_div ? (r_neg_r ? -w_step_hi : w_step_hi) : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_fix_lo   = r_is_div ? (r_neg_q ? -w_step_lo : w_step_lo) : w_prod_fix[WIDTH-1:0];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = w_dbz_req ? S_DONE : S_RUN;
      S_RUN: begin
        if (flush_i)             w_next_state = S_IDLE;
        else if (r_cnt == LAST)  w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o       = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    div_by_zero_o = 1'b0;
    if (rst_i) begin
      stall_o       = w_accept || (r_state == S_RUN);
      busy_o        = (r_state != S_IDLE);
      done_o        = (r_state == S_DONE);
      div_by_zero_o = (r_state == S_DONE) && r_dbz;
    end
  end

  // Operand latch, iteration datapath and HI/LO commit
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
      r_b      <= '0;
      r_wh     <= '0;
      r_wl     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_is_div <= op_i[1];
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_dbz    <= w_dbz_req;
      r_b      <= w_b_mag;
      r_wh     <= '0;
      r_wl     <= w_a_mag;
    end else if (r_state == S_RUN && !flush_i) begin
      r_cnt <= r_cnt + 1'b1;
      r_wh  <= w_step_hi;
      r_wl  <= w_step_lo;
      if (r_cnt == LAST) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule
